wb_spi_arbiter: RTL and testbench



---
 rtl/wb_spi_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/wb_spi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_spi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_pkg.sv
// ============================================================================
// Module : wb_spi_pkg
// Brief  : Shared constants, state encoding and select-pattern check for the
//          wb_spi requester arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_spi_pkg;

  localparam logic [3:0] SEL_32 = 4'b1111;
  localparam logic [3:0] SEL_16 = 4'b0011;
  localparam logic [3:0] SEL_8  = 4'b0001;

  localparam int SPI_CS0_BIT = 25;
  localparam int SPI_CS1_BIT = 26;
  localparam int SPI_CS2_BIT = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The SPI engine can only serialise full-word, low-half and low-byte writes.
  function automatic logic sel_ok(input logic [3:0] sel);
    return (sel == SEL_32) || (sel == SEL_16) || (sel == SEL_8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker: first requester after the
//          last-grant pointer, scanning circularly; one-hot result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int PTR_W = 1
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [PTR_W-1:0] i_last,
  output logic [NUM_M-1:0] o_grant
);

  // Scan farthest-first so the nearest requester after i_last wins.
  always_comb begin
    int idx;
    o_grant = '0;
    idx     = 0;
    for (int i = NUM_M; i >= 1; i--) begin
      idx = (int'(i_last) + i) % NUM_M;
      if (i_req[idx]) begin
        o_grant = NUM_M'(1) << idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_spi_arbiter.sv
// ============================================================================
// Module : wb_spi_arbiter
// Brief  : Round-robin sharing of the wb_spi slave port between NUM_M Wishbone
//          requesters, with write-select filtering and stall timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_spi_arbiter
  import wb_spi_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M*32-1:0]   m_adr_i,
  input  logic [NUM_M*32-1:0]   m_dat_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*4-1:0]    m_sel_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [31:0]           m_dat_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  output logic [3:0]            s_sel_o,
  input  logic                  s_ack_i,
  input  logic [31:0]           s_dat_i,
  output logic [NUM_M-1:0]      grant_o,
  output logic                  busy_o
);

  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit c_TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t             r_state;
  logic [NUM_M-1:0]   r_grant;
  logic [PTR_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out;
  logic               r_sel_blk;

  logic [NUM_M-1:0]   w_req;
  logic [NUM_M-1:0]   w_rr_grant;
  logic [PTR_W-1:0]   w_rr_idx;
  logic [31:0]        w_o_adr;
  logic [31:0]        w_o_dat;
  logic [3:0]         w_o_sel;
  logic               w_o_we;
  logic               w_o_stb;
  logic               w_o_cyc;
  logic               w_owned;
  logic               w_wr_block;
  logic               w_sel_bad;
  logic               w_stall;
  logic               w_to_owned;
  logic               w_to_drain;

  assign w_req = m_cyc_i & m_stb_i;

  rr_arbiter #(
    .NUM_M (NUM_M),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_rr_grant)
  );

  always_comb begin
    w_rr_idx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_rr_grant[k]) w_rr_idx = PTR_W'(k);
    end
  end

  // r_grant is only non-zero in OWNED, so the mux doubles as the output gate.
  always_comb begin
    w_o_adr = '0;
    w_o_dat = '0;
    w_o_sel = '0;
    w_o_we  = 1'b0;
    w_o_stb = 1'b0;
    w_o_cyc = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (r_grant[k]) begin
        w_o_adr = m_adr_i[32*k +: 32];
        w_o_dat = m_dat_i[32*k +: 32];
        w_o_sel = m_sel_i[4*k +: 4];
        w_o_we  = m_we_i[k];
        w_o_stb = m_stb_i[k];
        w_o_cyc = m_cyc_i[k];
      end
    end
  end

  assign w_owned    = (r_state == ST_OWNED);
  assign w_wr_block = w_o_we & ~sel_ok(w_o_sel);
  assign w_sel_bad  = w_owned & w_o_cyc & w_o_stb & w_wr_block & ~r_sel_blk;

  assign s_adr_o = w_o_adr;
  assign s_dat_o = w_o_dat;
  assign s_sel_o = w_o_sel;
  assign s_we_o  = w_o_we;
  assign s_cyc_o = w_owned & w_o_cyc;
  assign s_stb_o = w_owned & w_o_cyc & w_o_stb & ~w_wr_block & ~r_sel_blk;

  // A same-cycle ack removes the stall term, so ack always beats expiry.
  assign w_stall    = s_stb_o & ~s_ack_i;
  assign w_to_owned = c_TO_EN & w_owned & w_stall & (r_cnt == c_TO_LAST);
  assign w_to_drain = c_TO_EN & (r_state == ST_DRAIN) & ~s_ack_i & (r_cnt == c_TO_LAST);

  assign m_ack_o = r_grant & {NUM_M{s_ack_i & s_cyc_o & ~w_sel_bad}};
  assign m_err_o = r_grant & {NUM_M{w_sel_bad | w_to_owned}};
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;
  assign busy_o  = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_last    <= PTR_W'(NUM_M - 1);
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_sel_blk <= 1'b0;
    end else begin
      r_out <= w_stall;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_sel_blk <= 1'b0;
          if (|w_req) begin
            r_grant <= w_rr_grant;
            r_last  <= w_rr_idx;
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_to_owned) begin
            r_state   <= ST_DRAIN;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_sel_blk <= 1'b0;
          end else if (!w_o_cyc) begin
            r_state   <= (r_out && !s_ack_i) ? ST_DRAIN : ST_IDLE;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_sel_blk <= 1'b0;
          end else begin
            r_cnt <= w_stall ? r_cnt + 1'b1 : '0;
            if (w_sel_bad) begin
              r_sel_blk <= 1'b1;
            end else if (!w_o_stb) begin
              r_sel_blk <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (s_ack_i || w_to_drain) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_spi_arbiter.sv
// ============================================================================
// Module : tb_wb_spi_arbiter
// Brief  : Scoreboard bench for wb_spi_arbiter with a delayed-ack slave model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_spi_arbiter;

  localparam int NUM_M = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_M*32-1:0] m_adr_i = '0;
  logic [NUM_M*32-1:0] m_dat_i = '0;
  logic [NUM_M-1:0]    m_we_i  = '0;
  logic [NUM_M*4-1:0]  m_sel_i = '0;
  logic [NUM_M-1:0]    m_stb_i = '0;
  logic [NUM_M-1:0]    m_cyc_i = '0;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [31:0]         m_dat_o;
  logic [31:0]         s_adr_o;
  logic [31:0]         s_dat_o;
  logic                s_we_o;
  logic                s_stb_o;
  logic                s_cyc_o;
  logic [3:0]          s_sel_o;
  logic                s_ack_i = 1'b0;
  logic [31:0]         s_dat_i = '0;
  logic [NUM_M-1:0]    grant_o;
  logic                busy_o;

  wb_spi_arbiter #(.NUM_M(NUM_M), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack_i),
    .s_dat_i(s_dat_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
    bit          chk_dat;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void sb_push(input logic [1:0] ack, input logic [1:0] err,
                                  input logic [31:0] dat, input bit cd);
    exp_t e;
    e.ack = ack; e.err = err; e.dat = dat; e.chk_dat = cd;
    sb_q.push_back(e);
  endfunction

  // Slave: captures a strobe, acks sl_delay+1 cycles later even if cyc drops.
  int          sl_delay = 2;
  bit          sl_mute  = 1'b0;
  bit          sl_busy  = 1'b0;
  int          sl_cnt   = 0;
  logic [31:0] sl_data  = '0;

  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      s_ack_i = 1'b0; sl_busy = 1'b0; sl_cnt = 0;
    end else if (s_ack_i) begin
      s_ack_i = 1'b0;
    end else if (sl_busy) begin
      if (sl_cnt == 0) begin
        s_ack_i = 1'b1; s_dat_i = sl_data; sl_busy = 1'b0;
      end else begin
        sl_cnt--;
      end
    end else if (s_cyc_o && s_stb_o && !sl_mute) begin
      sl_busy = 1'b1;
      sl_cnt  = sl_delay;
      sl_data = s_we_o ? 32'h0 : (s_adr_o ^ 32'h5A5A_1234);
    end
  end

  // Monitor: every response seen on the requester side must match the queue head.
  always @(negedge clk) begin
    if (!rst && (m_ack_o != '0 || m_err_o != '0)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", {28'h0, m_ack_o, m_err_o}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_ack", {30'h0, m_ack_o}, {30'h0, e.ack});
        chk("resp_err", {30'h0, m_err_o}, {30'h0, e.err});
        if (e.chk_dat) chk("resp_dat", m_dat_o, e.dat);
      end
    end
  end

  task automatic drive(input int k, input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic [3:0] sel);
    m_adr_i[32*k +: 32] = adr;
    m_dat_i[32*k +: 32] = dat;
    m_sel_i[4*k +: 4]   = sel;
    m_we_i[k]  = we;
    m_stb_i[k] = 1'b1;
    m_cyc_i[k] = 1'b1;
  endtask

  task automatic release_m(input int k);
    m_stb_i[k] = 1'b0;
    m_cyc_i[k] = 1'b0;
    m_we_i[k]  = 1'b0;
    m_sel_i[4*k +: 4] = 4'h0;
  endtask

  task automatic wait_resp(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = m_ack_o[k] | m_err_o[k];
    end
    chk("resp_wait", {31'h0, seen}, 32'h1);
  endtask

  task automatic both_round(input int first, input int second);
    sb_push(2'(1 << first), 2'b00, 32'h0, 1'b0);
    sb_push(2'(1 << second), 2'b00, 32'h0, 1'b0);
    @(posedge clk) #1;
    drive(0, 32'h0800_0000, 32'h1111_0000, 1'b1, 4'hF);
    drive(1, 32'h0800_0004, 32'h1111_0001, 1'b1, 4'hF);
    fork
      begin
        wait_resp(first);
        @(posedge clk) #1 release_m(first);
        @(negedge clk) chk("rr_hold", {30'h0, grant_o}, 32'(1 << first));
        @(negedge clk) chk("rr_gap", {30'h0, grant_o}, 32'h0);
        @(negedge clk) chk("rr_next", {30'h0, grant_o}, 32'(1 << second));
      end
      begin
        wait_resp(second);
        @(posedge clk) #1 release_m(second);
      end
    join
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'h0, grant_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_s_ctl", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
    chk("rst_m_resp", {28'h0, m_ack_o, m_err_o}, 32'h0);
    @(posedge clk) #1 rst = 1'b0;

    // Single 32-bit write from requester 0
    sl_delay = 2;
    sb_push(2'b01, 2'b00, 32'h0, 1'b0);
    @(posedge clk) #1 drive(0, 32'h0800_0010, 32'hA5A5_0F0F, 1'b1, 4'hF);
    @(negedge clk) chk("t1_grant_latency", {30'h0, grant_o}, 32'h0);
    @(negedge clk);
    chk("t1_grant", {30'h0, grant_o}, 32'h1);
    chk("t1_stb", {31'h0, s_stb_o}, 32'h1);
    chk("t1_s_dat", s_dat_o, 32'hA5A5_0F0F);
    chk("t1_s_sel", {28'h0, s_sel_o}, 32'hF);
    wait_resp(0);
    chk("t1_ack_with_slave", {31'h0, s_ack_i}, 32'h1);
    @(posedge clk) #1 release_m(0);
    @(negedge clk) chk("t1_busy_hold", {31'h0, busy_o}, 32'h1);
    @(negedge clk) chk("t1_busy_fall", {30'h0, busy_o, grant_o[1]}, 32'h0);

    // Pointer now at 0: requester 1 wins the simultaneous round
    both_round(1, 0);

    // Write with an unserialisable select from requester 1
    sb_push(2'b00, 2'b10, 32'h0, 1'b0);
    @(posedge clk) #1 drive(1, 32'h0800_0020, 32'hDEAD_BEEF, 1'b1, 4'b0111);
    wait_resp(1);
    chk("t3_stb_blocked", {31'h0, s_stb_o}, 32'h0);
    @(negedge clk);
    chk("t3_err_single", {30'h0, m_err_o}, 32'h0);
    chk("t3_stb_still_blocked", {31'h0, s_stb_o}, 32'h0);
    chk("t3_no_ack", {30'h0, m_ack_o}, 32'h0);
    @(posedge clk) #1 release_m(1);
    @(negedge clk);
    @(negedge clk) chk("t3_idle", {31'h0, busy_o}, 32'h0);

    // Timeout: slave silent, error on the 8th stalled cycle, then 8-cycle drain
    sl_mute = 1'b1;
    sb_push(2'b00, 2'b01, 32'h0, 1'b0);
    @(posedge clk) #1 drive(0, 32'h0800_0030, 32'h0000_00C3, 1'b1, 4'b0001);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_stb_o) n++;
      if (m_err_o[0]) break;
    end
    chk("t4_stall_cycles", n, 32'd8);
    @(posedge clk) #1;
    release_m(0);
    sl_mute = 1'b0;
    sb_push(2'b10, 2'b00, 32'h5E5A_1214, 1'b1);
    drive(1, 32'h0400_0020, 32'h0, 1'b0, 4'hF);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_o && grant_o == 2'b00) nd++;
      else break;
    end
    chk("t4_drain_cycles", nd, 32'd8);
    chk("t4_idle_after_drain", {29'h0, busy_o, grant_o}, 32'h0);
    @(negedge clk) chk("t4_next_grant", {30'h0, grant_o}, 32'h2);
    wait_resp(1);
    @(posedge clk) #1 release_m(1);
    @(negedge clk);
    @(negedge clk);

    // Abort: owner drops cyc mid-write, late slave ack is swallowed
    sl_delay = 10;
    @(posedge clk) #1 drive(0, 32'h0800_0040, 32'h1234_5678, 1'b1, 4'hF);
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (s_stb_o) n++;
    end
    @(posedge clk) #1 release_m(0);
    @(negedge clk);
    chk("t5_s_ctl_dropped", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
    chk("t5_busy", {31'h0, busy_o}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = s_ack_i;
    end
    chk("t5_slave_ack", {31'h0, seen}, 32'h1);
    chk("t5_ack_swallowed", {30'h0, m_ack_o}, 32'h0);
    chk("t5_drain_busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk) chk("t5_idle", {31'h0, busy_o}, 32'h0);

    // Asynchronous reset while requester 1 owns the port
    sl_delay = 20;
    @(posedge clk) #1 drive(1, 32'h0800_0050, 32'h0BAD_F00D, 1'b1, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("t6_owned", {30'h0, grant_o}, 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_grant", {30'h0, grant_o}, 32'h0);
    chk("t6_rst_s_ctl", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy_o}, 32'h0);
    release_m(1);
    @(posedge clk) #1;
    @(posedge clk) #1 rst = 1'b0;
    sl_delay = 1;
    both_round(0, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
